selector41_scan: RTL
====================

# selector41_scan

Time-division transmitter for the active-low 1-to-4 demultiplexer. It snapshots four 1-bit channels once per frame and sends them one at a time on a single data line `oC`, with the channel address on `oS1`/`oS0`. `oC` and the select lines connect directly to the demultiplexer's `iC`/`iS1`/`iS0`: a selected output goes low only when its channel bit is 0, and unselected outputs idle high. A guard cycle before each channel keeps the idle level on `oC` while the select lines change, so no receiver output glitches low.

## Interface
- `DWELL`, default 4: cycles each channel is driven with valid data; legal range 1..255.
- `iClk`  in  1  clock; all state changes on the rising edge.
- `iRst`  in  1  synchronous, active-high reset.
- `iEn`  in  1  run request; sampled at frame boundaries only.
- `iD0`..`iD3`  in  1 each  channel data; sampled only at frame start.
- `oS1`, `oS0`  out  1 each  channel address (`{oS1,oS0}` = channel index); registered.
- `oC`  out  1  serial data line; idle/guard level 1; registered.
- `oValid`  out  1  high while `oC` carries channel data; registered.
- `oFrame`  out  1  one-cycle pulse during channel 0's guard cycle; registered.
- `oBusy`  out  1  high whenever the state is not IDLE; registered.

## Operation
- **State machine:** IDLE, SETUP (guard), HOLD.
- **Registers:** 2-bit channel index `ch`; 8-bit dwell counter; 4-bit shadow `sh`.
- **IDLE:**
  - `oC`=1, `oValid`=0, `oBusy`=0, `oFrame`=0; `oS` holds its last value.
  - If `iEn`=1: load `sh`={iD3,iD2,iD1,iD0}, set `ch`=0, go to SETUP.
- **SETUP:**
  - `oS`=`ch`, `oC`=1, `oValid`=0, `oBusy`=1.
  - `oFrame`=1 only when `ch`=0.
  - Load the dwell counter with DWELL-1; go to HOLD next cycle.
- **HOLD:**
  - `oS`=`ch`, `oC`=`sh[ch]`, `oValid`=1.
  - While the counter is nonzero, decrement it.
  - When the counter is 0 and `ch`<3: `ch`=`ch`+1, go to SETUP.
  - When the counter is 0 and `ch`=3 and `iEn`=1: reload `sh` from the inputs, set `ch`=0, go to SETUP. Frames run back to back with no IDLE cycle.
  - When the counter is 0 and `ch`=3 and `iEn`=0: go to IDLE.
- **Mid-frame `iEn` deassertion:** ignored. The frame always completes all four channels.
- **Input coherence:** changes on `iD*` during a frame do not affect that frame. The snapshot is atomic at the frame-start edge.
- **Channel index:** wraps 3 -> 0 only through the frame-end path.
- **Reset:**
  - Overrides everything, including mid-HOLD.
  - Next cycle: state=IDLE, `ch`=0, counter=0, `sh`=4'b1111.
  - Outputs: `oS1`=0, `oS0`=0, `oC`=1, `oValid`=0, `oFrame`=0, `oBusy`=0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Frame length is 4·(1+DWELL) cycles.
- Start of a frame: with `iEn`=1 in IDLE at edge t:
  - `iD*` are sampled at edge t.
  - After edge t: SETUP for channel 0 (`oFrame`=1, `oBusy`=1, `oS`=00, `oC`=1).
  - After edge t+1: `oValid`=1, `oC`=`iD0`@t, lasting DWELL cycles.
- Select-line changes occur only on entry to SETUP. `oC` is guaranteed 1 in the cycle the select changes.
- Back-to-back frames: channel 0's SETUP immediately follows channel 3's last HOLD cycle.
- Return to IDLE: `oBusy` falls in the cycle after channel 3's last HOLD cycle.
- With DWELL=1, each channel takes 2 cycles (SETUP, HOLD) and the frame is 8 cycles.

## Test plan
- **Reset values:** assert `iRst` for 2 cycles with `iEn`=1 -> outputs `oS`=00, `oC`=1, `oValid`=0, `oFrame`=0, `oBusy`=0 throughout.
- **Single frame, DWELL=2:** `iD`=4'b0101, `iEn`=1 for one cycle then 0 -> `oS` sequence 00,01,10,11. `oC` during HOLD = 1,0,1,0, each for 2 cycles. `oC`=1 in each SETUP cycle. `oFrame` pulses once. Exactly 12 busy cycles, then IDLE.
- **Snapshot coherence:** start a frame with `iD`=4'b0000, then change to 4'b1111 during channel 1's HOLD -> all four HOLD phases show `oC`=0.
- **Continuous run, DWELL=1:** `iEn` held at 1 with `iD`=4'b1010 -> period-8 pattern, `oFrame` every 8 cycles, no IDLE gap. Deassert `iEn` mid-frame -> the current frame completes and `oBusy` drops right after channel 3.
- **Reset mid-HOLD:** `iRst` pulsed during channel 2's HOLD -> next cycle shows all reset values. With `iEn`=1, the next frame starts at channel 0 with a fresh snapshot.
- **Receiver loopback:** connect to the 1-to-4 demux with `iD`=4'b1101 -> only receiver output 1 goes low, only during channel 1's HOLD. Outputs 0, 2 and 3 never go low, including across SETUP transitions.

Source files
------------

// File: rtl/selector41_scan.sv
// Time-division transmitter: snapshots four 1-bit channels per frame and serialises
// them onto oC with the channel address on oS1/oS0, inserting an idle-high guard cycle.
module selector41_scan #(
  parameter int unsigned DWELL = 4
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iEn,
  input  logic iD0,
  input  logic iD1,
  input  logic iD2,
  input  logic iD3,
  output logic oS1,
  output logic oS0,
  output logic oC,
  output logic oValid,
  output logic oFrame,
  output logic oBusy
);

  typedef enum logic [1:0] {IDLE, SETUP, HOLD} state_t;

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

  state_t     state, state_n;
  logic [1:0] ch, ch_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] sh, sh_n;

  logic [1:0] sel_n;
  logic       c_n, valid_n, frame_n, busy_n;

  always_comb begin
    state_n = state;
    ch_n    = ch;
    cnt_n   = cnt;
    sh_n    = sh;
    case (state)
      IDLE: begin
        if (iEn) begin
          sh_n    = {iD3, iD2, iD1, iD0};
          ch_n    = 2'd0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        cnt_n   = DWELL_M1;
        state_n = HOLD;
      end
      HOLD: begin
        if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
        end else if (ch != 2'd3) begin
          ch_n    = ch + 2'd1;
          state_n = SETUP;
        end else if (iEn) begin
          // back-to-back frame: fresh snapshot, no idle gap
          sh_n    = {iD3, iD2, iD1, iD0};
          ch_n    = 2'd0;
          state_n = SETUP;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every output is a flop.
  always_comb begin
    sel_n   = {oS1, oS0};
    c_n     = 1'b1;
    valid_n = 1'b0;
    frame_n = 1'b0;
    busy_n  = (state_n != IDLE);
    if (state_n != IDLE) sel_n = ch_n;
    if (state_n == HOLD) begin
      c_n     = sh_n[ch_n];
      valid_n = 1'b1;
    end
    if (state_n == SETUP && ch_n == 2'd0) frame_n = 1'b1;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state  <= IDLE;
      ch     <= 2'd0;
      cnt    <= 8'd0;
      sh     <= 4'b1111;
      oS1    <= 1'b0;
      oS0    <= 1'b0;
      oC     <= 1'b1;
      oValid <= 1'b0;
      oFrame <= 1'b0;
      oBusy  <= 1'b0;
    end else begin
      state  <= state_n;
      ch     <= ch_n;
      cnt    <= cnt_n;
      sh     <= sh_n;
      oS1    <= sel_n[1];
      oS0    <= sel_n[0];
      oC     <= c_n;
      oValid <= valid_n;
      oFrame <= frame_n;
      oBusy  <= busy_n;
    end
  end

endmodule
